pipe_hazard_scoreboard: RTL and testbench

- Parametrised hazard and forwarding controller for the in-order pipeline.
- Replaces the fixed 5-stage hazard detector and forwarding unit with one block that tracks in-flight destination registers across DEPTH post-decode stages. Slot 0 is EX and slot DEPTH-1 is WB.
- Sits beside decode. It produces a decode stall, per-operand forwarding selects, and handles a branch flush and a data-memory freeze.

---
 rtl/pipe_hazard_scoreboard.sv | 182 ++++++++++++++++++
 tb/tb_pipe_hazard_scoreboard.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_scoreboard.sv
// pipe_hazard_scoreboard
// Hazard and forwarding controller for the in-order pipeline. Tracks the
// destination register of every instruction in the DEPTH stages after decode
// (slot 0 = EX, slot DEPTH-1 = WB). From that state it derives the
// load-use stall and the per-operand forwarding selects, and it inserts
// bubbles on a taken branch (flush) or holds everything on a data-memory
// freeze.
//
// Optional build macro: HAZ_PERF_CNT_EN
//   When defined, two saturating 16-bit event counters are added as outputs:
//   perf_stall_cnt (stalled, unfrozen cycles) and perf_flush_cnt (valid
//   decode instructions killed by an unfrozen flush).
//
// Decode-side outputs are combinational because decode needs them in the
// same cycle. They are qualified by ready_r so that every output reads 0
// while reset is held and on the first cycle after reset is released.

module pipe_hazard_scoreboard #(
    parameter int REG_AW     = 3,
    parameter int DEPTH      = 3,
    parameter int LOAD_STAGE = 2,
    parameter int SEL_W      = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    input  logic [REG_AW-1:0] issue_rs,
    input  logic              issue_rs_rd,
    input  logic [REG_AW-1:0] issue_rt,
    input  logic              issue_rt_rd,
    input  logic              issue_wr_en,
    input  logic [REG_AW-1:0] issue_dest,
    input  logic              issue_is_load,
    input  logic              freeze,
    input  logic              flush,
    output logic              stall,
    output logic              fwd_rs_en,
    output logic [SEL_W-1:0]  fwd_rs_sel,
    output logic              fwd_rt_en,
    output logic [SEL_W-1:0]  fwd_rt_sel,
    output logic [SEL_W:0]    occupancy,
    output logic              accepted
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [15:0]       perf_stall_cnt,
    output logic [15:0]       perf_flush_cnt
`endif
);

    // Index of the youngest (lowest-numbered) set bit; 0 when none is set.
    function automatic logic [SEL_W-1:0] youngest_idx(input logic [DEPTH-1:0] hits);
        logic [SEL_W-1:0] idx;
        idx = {SEL_W{1'b0}};
        for (int i = DEPTH - 1; i >= 0; i--) begin
            idx = hits[i] ? SEL_W'(i) : idx;
        end
        return idx;
    endfunction

    // Number of set bits in a slot-valid vector.
    function automatic logic [SEL_W:0] popcount(input logic [DEPTH-1:0] v);
        logic [SEL_W:0] cnt;
        cnt = {(SEL_W + 1){1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            cnt = cnt + {{SEL_W{1'b0}}, v[i]};
        end
        return cnt;
    endfunction

    // Per-slot tracked state.
    logic [DEPTH-1:0]  slot_valid_r;
    logic [DEPTH-1:0]  slot_wr_en_r;
    logic [DEPTH-1:0]  slot_is_load_r;
    logic [REG_AW-1:0] slot_dest_r [DEPTH];

    // Goes high one clock after reset release; qualifies decode-side outputs.
    logic              ready_r;
    logic [SEL_W:0]    occupancy_r;

    // Matching network.
    logic [DEPTH-1:0]  rs_hits_s;
    logic [DEPTH-1:0]  rt_hits_s;
    logic [DEPTH-1:0]  rs_first_s;
    logic [DEPTH-1:0]  rt_first_s;
    logic [DEPTH-1:0]  early_load_s;
    logic              rs_haz_s;
    logic              rt_haz_s;
    logic              stall_s;
    logic              accepted_s;
    logic [DEPTH-1:0]  next_valid_s;

    // Per-slot comparators: which slots would supply each source, and which
    // slots hold a load whose data is not yet available for forwarding.
    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        assign rs_hits_s[g] = issue_rs_rd & slot_valid_r[g] & slot_wr_en_r[g]
                              & (slot_dest_r[g] == issue_rs);
        assign rt_hits_s[g] = issue_rt_rd & slot_valid_r[g] & slot_wr_en_r[g]
                              & (slot_dest_r[g] == issue_rt);
        assign early_load_s[g] = slot_is_load_r[g] & ((g < LOAD_STAGE) ? 1'b1 : 1'b0);
    end

    // Isolate the youngest matching slot; only that slot decides the hazard,
    // so a younger ALU result shadows an older load still in flight.
    assign rs_first_s = rs_hits_s & (~rs_hits_s + DEPTH'(1'b1));
    assign rt_first_s = rt_hits_s & (~rt_hits_s + DEPTH'(1'b1));
    assign rs_haz_s   = |(rs_first_s & early_load_s);
    assign rt_haz_s   = |(rt_first_s & early_load_s);

    // A flush overrides a stall: the decode instruction is killed anyway.
    assign stall_s    = ready_r & issue_valid & ~flush & (rs_haz_s | rt_haz_s);
    assign accepted_s = ready_r & issue_valid & ~stall_s & ~flush & ~freeze;

    // Valid vector the slots take on the next unfrozen edge.
    assign next_valid_s = {slot_valid_r[DEPTH-2:0], accepted_s};

    assign stall      = stall_s;
    assign accepted   = accepted_s;
    assign occupancy  = occupancy_r;
    assign fwd_rs_en  = ready_r & (|rs_hits_s);
    assign fwd_rt_en  = ready_r & (|rt_hits_s);
    assign fwd_rs_sel = fwd_rs_en ? youngest_idx(rs_hits_s) : {SEL_W{1'b0}};
    assign fwd_rt_sel = fwd_rt_en ? youngest_idx(rt_hits_s) : {SEL_W{1'b0}};

    // Reset-release qualifier: low in reset and for the first cycle after.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_r <= 1'b0;
        end else begin
            ready_r <= 1'b1;
        end
    end

    // Slot shift register: advance one stage per unfrozen cycle, load the
    // accepted decode instruction (or a bubble) into slot 0, hold on freeze.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_valid_r   <= {DEPTH{1'b0}};
            slot_wr_en_r   <= {DEPTH{1'b0}};
            slot_is_load_r <= {DEPTH{1'b0}};
            occupancy_r    <= {(SEL_W + 1){1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                slot_dest_r[i] <= {REG_AW{1'b0}};
            end
        end else if (!freeze) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                slot_valid_r[i]   <= slot_valid_r[i-1];
                slot_wr_en_r[i]   <= slot_wr_en_r[i-1];
                slot_is_load_r[i] <= slot_is_load_r[i-1];
                slot_dest_r[i]    <= slot_dest_r[i-1];
            end
            slot_valid_r[0]   <= accepted_s;
            slot_wr_en_r[0]   <= accepted_s & issue_wr_en;
            slot_is_load_r[0] <= accepted_s & issue_is_load;
            slot_dest_r[0]    <= accepted_s ? issue_dest : {REG_AW{1'b0}};
            occupancy_r       <= popcount(next_valid_s);
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [15:0] perf_stall_cnt_r;
    logic [15:0] perf_flush_cnt_r;

    // Saturating counts of stalled cycles and of killed decode instructions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_cnt_r <= 16'h0000;
            perf_flush_cnt_r <= 16'h0000;
        end else begin
            if (stall_s && !freeze && (perf_stall_cnt_r != 16'hFFFF)) begin
                perf_stall_cnt_r <= perf_stall_cnt_r + 16'h0001;
            end
            if (flush && !freeze && issue_valid && (perf_flush_cnt_r != 16'hFFFF)) begin
                perf_flush_cnt_r <= perf_flush_cnt_r + 16'h0001;
            end
        end
    end

    assign perf_stall_cnt = perf_stall_cnt_r;
    assign perf_flush_cnt = perf_flush_cnt_r;
`endif

endmodule

// File: tb/tb_pipe_hazard_scoreboard.sv
// Self-checking bench for pipe_hazard_scoreboard (DEPTH=3, LOAD_STAGE=2).
// A behavioural model holds the in-flight instructions by age and derives
// every expected output from the hazard/forwarding rules; one negedge
// process compares against it each cycle, and directed sequences add
// hand-computed literal expectations.

module tb_pipe_hazard_scoreboard;

    localparam int REG_AW     = 3;
    localparam int DEPTH      = 3;
    localparam int LOAD_STAGE = 2;
    localparam int SEL_W      = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              issue_valid, issue_rs_rd, issue_rt_rd, issue_wr_en, issue_is_load;
    logic [REG_AW-1:0] issue_rs, issue_rt, issue_dest;
    logic              freeze, flush;
    logic              stall, fwd_rs_en, fwd_rt_en, accepted;
    logic [SEL_W-1:0]  fwd_rs_sel, fwd_rt_sel;
    logic [SEL_W:0]    occupancy;
`ifdef HAZ_PERF_CNT_EN
    logic [15:0]       perf_stall_cnt, perf_flush_cnt;
`endif

    pipe_hazard_scoreboard #(
        .REG_AW(REG_AW), .DEPTH(DEPTH), .LOAD_STAGE(LOAD_STAGE), .SEL_W(SEL_W)
    ) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_rs(issue_rs), .issue_rs_rd(issue_rs_rd),
        .issue_rt(issue_rt), .issue_rt_rd(issue_rt_rd), .issue_wr_en(issue_wr_en),
        .issue_dest(issue_dest), .issue_is_load(issue_is_load),
        .freeze(freeze), .flush(flush),
        .stall(stall), .fwd_rs_en(fwd_rs_en), .fwd_rs_sel(fwd_rs_sel),
        .fwd_rt_en(fwd_rt_en), .fwd_rt_sel(fwd_rt_sel),
        .occupancy(occupancy), .accepted(accepted)
`ifdef HAZ_PERF_CNT_EN
        , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m[a] is the instruction that entered the pipeline a unfrozen cycles ago.
    typedef struct packed {
        logic              v;
        logic              w;
        logic [REG_AW-1:0] d;
        logic              l;
    } inst_t;

    inst_t       m [DEPTH];
    logic        mready;
    logic [15:0] m_stall_cnt, m_flush_cnt;

    logic e_rs_hit, e_rt_hit, e_rs_haz, e_rt_haz, e_stall, e_acc;
    int   e_rs_idx, e_rt_idx, e_occ;

    task automatic reset_model();
        for (int a = 0; a < DEPTH; a++) m[a] = '0;
        mready      = 1'b0;
        m_stall_cnt = 16'h0000;
        m_flush_cnt = 16'h0000;
    endtask

    // The most recent writer of src decides; its data is usable unless it
    // is a load that has not yet reached LOAD_STAGE.
    task automatic look(input logic rd, input logic [REG_AW-1:0] src,
                        output logic hit, output int idx, output logic haz);
        hit = 1'b0; idx = 0; haz = 1'b0;
        if (rd) begin
            for (int a = 0; a < DEPTH; a++) begin
                if (m[a].v && m[a].w && m[a].d == src) begin
                    hit = 1'b1;
                    idx = a;
                    haz = m[a].l && (a < LOAD_STAGE);
                    break;
                end
            end
        end
    endtask

    task automatic model_eval();
        look(issue_rs_rd, issue_rs, e_rs_hit, e_rs_idx, e_rs_haz);
        look(issue_rt_rd, issue_rt, e_rt_hit, e_rt_idx, e_rt_haz);
        e_stall = mready && issue_valid && !flush && (e_rs_haz || e_rt_haz);
        e_acc   = mready && issue_valid && !e_stall && !flush && !freeze;
        e_occ   = 0;
        for (int a = 0; a < DEPTH; a++) e_occ += m[a].v ? 1 : 0;
    endtask

    // Model advance on each clock edge (inputs are stable around the edge).
    always @(posedge clk) begin
        if (!rst) begin
            model_eval();
            if (!freeze) begin
                if (e_stall && m_stall_cnt != 16'hFFFF) m_stall_cnt = m_stall_cnt + 16'h0001;
                if (flush && issue_valid && m_flush_cnt != 16'hFFFF) m_flush_cnt = m_flush_cnt + 16'h0001;
                for (int a = DEPTH - 1; a > 0; a--) m[a] = m[a-1];
                m[0] = e_acc ? {1'b1, issue_wr_en, issue_dest, issue_is_load} : '0;
            end
            mready = 1'b1;
        end
    end

    // Single compare process: every output against the model each cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            model_eval();
            check("stall", stall, e_stall);
            check("accepted", accepted, e_acc);
            check("occupancy", occupancy, e_occ);
            // Forwarding selects are don't-care while a source is hazardous.
            if (!e_rs_haz && !e_rt_haz) begin
                check("fwd_rs_en", fwd_rs_en, mready && e_rs_hit);
                check("fwd_rs_sel", fwd_rs_sel, (mready && e_rs_hit) ? e_rs_idx : 0);
                check("fwd_rt_en", fwd_rt_en, mready && e_rt_hit);
                check("fwd_rt_sel", fwd_rt_sel, (mready && e_rt_hit) ? e_rt_idx : 0);
            end
`ifdef HAZ_PERF_CNT_EN
            check("perf_stall_cnt", perf_stall_cnt, m_stall_cnt);
            check("perf_flush_cnt", perf_flush_cnt, m_flush_cnt);
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic iv, input logic [2:0] rs, input logic rsrd,
                         input logic [2:0] rt, input logic rtrd, input logic we,
                         input logic [2:0] dest, input logic ld, input logic frz,
                         input logic fl);
        issue_valid = iv;  issue_rs = rs;  issue_rs_rd = rsrd;
        issue_rt = rt;     issue_rt_rd = rtrd;
        issue_wr_en = we;  issue_dest = dest; issue_is_load = ld;
        freeze = frz;      flush = fl;
    endtask

    task automatic idle();
        drive(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    // Bounded run time.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_model();
        // Reset held with a would-be hazardous reader in decode: all outputs 0.
        drive(1'b1, 3'd1, 1'b1, 3'd2, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0);
        at_neg();
        check("rst_stall", stall, 1'b0);
        check("rst_accepted", accepted, 1'b0);
        check("rst_fwd_rs_en", fwd_rs_en, 1'b0);
        check("rst_fwd_rt_en", fwd_rt_en, 1'b0);
        check("rst_occupancy", occupancy, 4'd0);
        tick();
        rst = 1'b0;
        chk_en = 1'b1;
        // First cycle after release: a valid decode is still not accepted.
        drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        at_neg();
        check("post_rst_accepted", accepted, 1'b0);
        tick();
        idle();
        tick();

        // ALU back-to-back: wr r3, then read rs=r3 forwards from slot 0.
        drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0);
        at_neg();
        check("alu_wr_accepted", accepted, 1'b1);
        tick();
        drive(1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        at_neg();
        check("alu_stall", stall, 1'b0);
        check("alu_fwd_rs_en", fwd_rs_en, 1'b1);
        check("alu_fwd_rs_sel", fwd_rs_sel, 3'd0);
        tick();

        // Load-use: load r2, dependent reads rt=r2 -> two stall cycles.
        drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 3'd0, 1'b0, 3'd2, 1'b1, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0);
        at_neg();
        check("lu_stall_c1", stall, 1'b1);
        check("lu_acc_c1", accepted, 1'b0);
        tick();
        at_neg();
        check("lu_stall_c2", stall, 1'b1);
        tick();
        at_neg();
        check("lu_stall_c3", stall, 1'b0);
        check("lu_fwd_rt_en", fwd_rt_en, 1'b1);
        check("lu_fwd_rt_sel", fwd_rt_sel, 3'd2);
        check("lu_acc_c3", accepted, 1'b1);
        tick();

        // Youngest wins: r5 in slots 2 and 0, r6 in slot 1.
        drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd6, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b1, 3'd5, 1'b1, 3'd6, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        at_neg();
        check("yw_fwd_rs_sel", fwd_rs_sel, 3'd0);
        check("yw_fwd_rt_sel", fwd_rt_sel, 3'd1);
        check("yw_stall", stall, 1'b0);
        tick();

        // A younger ALU write shadows an older, still hazardous load.
        drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd7, 1'b1, 1'b0, 1'b0); tick();
        drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd7, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b1, 3'd7, 1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        at_neg();
        check("shadow_stall", stall, 1'b0);
        check("shadow_fwd_rs_sel", fwd_rs_sel, 3'd0);
        tick();

        // A younger load over an older ALU write of the same register stalls.
        drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd6, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd6, 1'b1, 1'b0, 1'b0); tick();
        drive(1'b1, 3'd0, 1'b0, 3'd6, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        at_neg(); check("yl_stall_c1", stall, 1'b1); tick();
        at_neg(); check("yl_stall_c2", stall, 1'b1); tick();
        at_neg(); check("yl_fwd_rt_sel", fwd_rt_sel, 3'd2); tick();

        // Read flags clear: no forwarding and no hazard against a fresh load.
        drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0); tick();
        drive(1'b1, 3'd1, 1'b0, 3'd1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        at_neg();
        check("nord_stall", stall, 1'b0);
        check("nord_fwd_rs_en", fwd_rs_en, 1'b0);
        check("nord_fwd_rt_sel", fwd_rt_sel, 3'd0);
        tick();

        // Freeze: load r1 in slot 0, four frozen cycles, then two stalls.
        idle(); tick(); tick(); tick();
        drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0); tick();
        drive(1'b1, 3'd1, 1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            at_neg();
            check("frz_stall", stall, 1'b1);
            check("frz_occupancy", occupancy, 4'd1);
            check("frz_accepted", accepted, 1'b0);
            tick();
        end
        freeze = 1'b0;
        at_neg(); check("frz_rel_stall_c1", stall, 1'b1); tick();
        at_neg(); check("frz_rel_stall_c2", stall, 1'b1); tick();
        at_neg();
        check("frz_rel_stall_c3", stall, 1'b0);
        check("frz_rel_fwd_rs_sel", fwd_rs_sel, 3'd2);
        tick();

        // Flush during a load-use hazard: no stall, bubble into slot 0.
        idle(); tick(); tick(); tick();
        drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0); tick();
        drive(1'b1, 3'd0, 1'b0, 3'd2, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
        at_neg();
        check("fl_stall", stall, 1'b0);
        check("fl_accepted", accepted, 1'b0);
        tick();
        idle();
        at_neg();
        check("fl_occupancy", occupancy, 4'd1);
        tick();

        // Async reset mid-stream with all slots full.
        drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b1, 3'd3, 1'b1, 3'd2, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        at_neg();
        check("full_occupancy", occupancy, 4'd3);
        @(posedge clk);
        #2;
        rst = 1'b1;
        reset_model();
        #1;
        check("arst_occupancy", occupancy, 4'd0);
        check("arst_stall", stall, 1'b0);
        check("arst_fwd_rs_en", fwd_rs_en, 1'b0);
        check("arst_fwd_rt_en", fwd_rt_en, 1'b0);
`ifdef HAZ_PERF_CNT_EN
        check("arst_perf_stall", perf_stall_cnt, 16'h0000);
        check("arst_perf_flush", perf_flush_cnt, 16'h0000);
`endif
        #1;
        rst = 1'b0;
        tick();
        idle();
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
